fft_arb: RTL

FFT_ARB -- requirements
Module: fft_arb

---
 rtl/fft_pkg.sv | 23 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/fft_arb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT core front-end arbiter.
//   state_e   : one-hot arbiter state encoding
//   LEN_*     : position of the transform length field inside a config word
//   MODE_BIT  : transform direction bit inside a config word (0=FFT, 1=IFFT)
// ----------------------------------------------------------------------------
package fft_pkg;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_CFG  = 4'b0010,
        ST_LOAD = 4'b0100,
        ST_WAIT = 4'b1000
    } state_e;

    // Config word field layout.
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned LEN_MSB  = 15;
    localparam int unsigned MODE_BIT = 16;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector: returns the first set request at
// or after ptr, scanning upwards and wrapping from NUM_CH-1 back to 0.
//   req  : request vector
//   ptr  : index where the scan starts (always < NUM_CH)
//   gnt  : one-hot selected request (zero when nothing requests)
//   idx  : binary index of the selected request
//   any  : at least one request is set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    int unsigned     pos;
    logic [CH_W-1:0] pos_w;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        pos_w = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pos   = (32'(ptr) + k) % NUM_CH;
            pos_w = CH_W'(pos);
            // First hit wins; later hits in the scan are ignored.
            if (!any && req[pos_w]) begin
                any        = 1'b1;
                gnt[pos_w] = 1'b1;
                idx        = pos_w;
            end
        end
    end

endmodule

// File: rtl/fft_arb.sv
// ----------------------------------------------------------------------------
// fft_arb
// Shares one FFT core between NUM_CH channels. A channel is granted round-robin,
// its config word is pushed to the core only when it differs from the last one
// accepted, then its frame is passed straight through to the core input. The
// arbiter then waits for the core to finish output before granting again.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   req                 : per-channel frame pending (held until frame accepted)
//   ch_cfg              : per-channel config words, slice i = channel i
//   grant               : one-hot owner of the core, zero when idle/waiting
//   s_valid/s_last      : per-channel input stream
//   s_ready             : per-channel ready, only the granted channel can see 1
//   m_cfg_valid/data    : config handshake to the core (registered)
//   m_cfg_ready         : core accepts config
//   m_valid/m_last      : stream to the core (passthrough from granted channel)
//   m_ready             : core accepts stream beat
//   fft_odone           : core finished outputting the current frame
//   out_ch              : channel whose frame the core is computing/outputting
//   busy                : arbiter not idle
// ----------------------------------------------------------------------------
module fft_arb
    import fft_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CFG_WIDTH = 24,
    parameter int unsigned CH_W      = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH*CFG_WIDTH-1:0] ch_cfg,
    output logic [NUM_CH-1:0]           grant,
    input  logic [NUM_CH-1:0]           s_valid,
    input  logic [NUM_CH-1:0]           s_last,
    output logic [NUM_CH-1:0]           s_ready,
    output logic                        m_cfg_valid,
    output logic [CFG_WIDTH-1:0]        m_cfg_data,
    input  logic                        m_cfg_ready,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    input  logic                        fft_odone,
    output logic [CH_W-1:0]             out_ch,
    output logic                        busy
);

    state_e               state;
    logic [CH_W-1:0]      rr_ptr;
    logic [CH_W-1:0]      gidx;       // binary index of the current grant
    logic [CFG_WIDTH-1:0] last_cfg;   // last config the core accepted
    logic                 cfg_vld;    // last_cfg holds a real config

    logic [NUM_CH-1:0]    pick_gnt;
    logic [CH_W-1:0]      pick_idx;
    logic                 pick_any;

    logic [CFG_WIDTH-1:0] cfg_arr [NUM_CH];
    logic [CFG_WIDTH-1:0] pick_cfg;
    logic                 need_cfg;
    logic                 in_load;
    logic                 frame_end;

    // ------------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------------
    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_arr[i] = ch_cfg[i*CFG_WIDTH +: CFG_WIDTH];
        end
    end

    assign pick_cfg = cfg_arr[pick_idx];
    // Reconfigure unless the core already holds exactly this config.
    assign need_cfg = !cfg_vld || (pick_cfg != last_cfg);

    // ------------------------------------------------------------------------
    // Stream passthrough while loading; everything else sees ready low.
    // ------------------------------------------------------------------------
    assign in_load = (state == ST_LOAD);

    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        s_ready = '0;
        if (in_load) begin
            m_valid = s_valid[gidx];
            m_last  = s_last[gidx];
            s_ready = grant & {NUM_CH{m_ready}};
        end
    end

    assign frame_end = m_valid && m_ready && m_last;
    assign busy      = (state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Arbiter FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            gidx        <= '0;
            rr_ptr      <= '0;
            m_cfg_valid <= 1'b0;
            m_cfg_data  <= '0;
            last_cfg    <= '0;
            cfg_vld     <= 1'b0;
            out_ch      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant  <= pick_gnt;
                        gidx   <= pick_idx;
                        rr_ptr <= (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
                        if (need_cfg) begin
                            state       <= ST_CFG;
                            m_cfg_valid <= 1'b1;
                            m_cfg_data  <= pick_cfg;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_CFG: begin
                    // Valid and data stay put until the core takes them.
                    if (m_cfg_ready) begin
                        last_cfg    <= m_cfg_data;
                        cfg_vld     <= 1'b1;
                        m_cfg_valid <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (frame_end) begin
                        state  <= ST_WAIT;
                        grant  <= '0;
                        out_ch <= gidx;
                    end
                end
                ST_WAIT: begin
                    if (fft_odone) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant       <= '0;
                    m_cfg_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    a_cfg_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (m_cfg_valid && !m_cfg_ready) |=> (m_cfg_valid && $stable(m_cfg_data)));

    a_ready_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (s_ready & ~grant) == '0);

endmodule
